othello_task_feeder: RTL and testbench

- Sits directly upstream and downstream of the multi-slot Othello endgame solver pipeline.
- Buffers incoming board tasks, each with a tag, and presents the head board on the solver's board inputs.
- Records which task each solver slot took, and pairs each solved pulse with its task tag.
- Emits {tag, result} on a valid/ready stream, using credits so no result is ever lost.

---
 rtl/othello_task_feeder.sv | 128 ++++++++++++
 tb/tb_othello_task_feeder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/othello_task_feeder.sv
// Task/result feeder around the multi-slot Othello endgame solver.
// Queues tagged boards, tracks which slot holds which tag, and streams {tag, score} back with credit control.
module othello_task_feeder #(
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16,
  parameter int TAG_W     = 8,
  parameter int SLOTS     = 16
) (
  input  logic             iCLOCK,
  input  logic             iRESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_player,
  input  logic [63:0]      in_opponent,
  input  logic [TAG_W-1:0] in_tag,
  output logic [63:0]      oPlayer,
  output logic [63:0]      oOpponent,
  input  logic             iTake,
  input  logic [3:0]       iTakeSlot,
  input  logic             iSolved,
  input  logic [3:0]       iSolvedSlot,
  input  logic [7:0]       iRes,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [7:0]       out_res,
  output logic [4:0]       oInflight
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int CW  = $clog2(OUT_DEPTH + SLOTS) + 1;

  typedef struct packed {
    logic [63:0]      player;
    logic [63:0]      opponent;
    logic [TAG_W-1:0] tag;
  } task_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [7:0]       res;
  } result_t;

  task_t   in_mem  [IN_DEPTH];
  result_t out_mem [OUT_DEPTH];
  logic [TAG_W-1:0] slot_tag [SLOTS];
  logic [SLOTS-1:0] slot_valid;

  logic [IAW:0] in_wr, in_rd;
  logic [OAW:0] out_wr, out_rd, out_count;
  logic in_empty, in_full, in_push, in_pop;
  logic out_empty, out_full, out_push, out_pop;
  logic grant, solve_hit, take_prev;
  logic [CW-1:0] credit_used;
  logic [4:0] inflight_nxt;
  task_t   head;
  result_t out_head;

  assign in_empty = (in_wr == in_rd);
  assign in_full  = (in_wr[IAW] != in_rd[IAW]) && (in_wr[IAW-1:0] == in_rd[IAW-1:0]);
  assign in_ready = !in_full;
  assign in_push  = in_valid && in_ready;
  assign head     = in_mem[in_rd[IAW-1:0]];

  assign out_empty = (out_wr == out_rd);
  assign out_full  = (out_wr[OAW] != out_rd[OAW]) && (out_wr[OAW-1:0] == out_rd[OAW-1:0]);
  assign out_count = out_wr - out_rd;
  assign out_head  = out_mem[out_rd[OAW-1:0]];

  // A solve moves its credit from oInflight to out_count on the same edge,
  // so no result is ever in transit outside these two counters.
  assign credit_used = CW'(oInflight) + CW'(out_count);
  assign grant       = !in_empty && (credit_used < CW'(OUT_DEPTH));

  assign oPlayer   = grant ? head.player   : 64'hFFFF_FFFF_FFFF_FFFF;
  assign oOpponent = grant ? head.opponent : 64'h0;

  assign in_pop    = iTake && grant;
  assign solve_hit = iSolved && slot_valid[iSolvedSlot];
  assign out_push  = solve_hit;
  assign out_valid = !out_empty;
  assign out_pop   = out_valid && out_ready;
  assign out_tag   = out_valid ? out_head.tag : '0;
  assign out_res   = out_valid ? out_head.res : '0;

  // Take sees the slot as already vacated when the same-edge solve hits it.
  always_comb begin
    take_prev    = slot_valid[iTakeSlot] && !(solve_hit && (iSolvedSlot == iTakeSlot));
    inflight_nxt = oInflight;
    if (solve_hit)
      inflight_nxt = inflight_nxt - 5'd1;
    if (iTake && grant && !take_prev)
      inflight_nxt = inflight_nxt + 5'd1;
    else if (iTake && !grant && take_prev)
      inflight_nxt = inflight_nxt - 5'd1;
  end

  always_ff @(posedge iCLOCK) begin
    if (in_push)
      in_mem[in_wr[IAW-1:0]] <= {in_player, in_opponent, in_tag};
    if (out_push)
      out_mem[out_wr[OAW-1:0]] <= {slot_tag[iSolvedSlot], iRes};
    if (in_pop)
      slot_tag[iTakeSlot] <= head.tag;
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      in_wr      <= '0;
      in_rd      <= '0;
      out_wr     <= '0;
      out_rd     <= '0;
      slot_valid <= '0;
      oInflight  <= '0;
    end else begin
      assert (!(out_push && out_full));
      if (in_push)  in_wr  <= in_wr + 1'b1;
      if (in_pop)   in_rd  <= in_rd + 1'b1;
      if (out_push) out_wr <= out_wr + 1'b1;
      if (out_pop)  out_rd <= out_rd + 1'b1;
      if (solve_hit)
        slot_valid[iSolvedSlot] <= 1'b0;
      if (iTake)
        slot_valid[iTakeSlot] <= grant;
      oInflight <= inflight_nxt;
    end
  end
endmodule

// File: tb/tb_othello_task_feeder.sv
// Directed bench for othello_task_feeder: queue-based reference model checked every cycle plus literal spot checks.
module tb_othello_task_feeder;
  localparam int D = 16;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] OPEN_P = 64'h0000_0008_1000_0000;
  localparam logic [63:0] OPEN_O = 64'h0000_0010_0800_0000;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic [63:0] in_player, in_opponent, oPlayer, oOpponent;
  logic [7:0] in_tag, iRes, out_tag, out_res;
  logic iTake, iSolved, out_valid, out_ready;
  logic [3:0] iTakeSlot, iSolvedSlot;
  logic [4:0] oInflight;

  always #5 clk = ~clk;

  othello_task_feeder dut (
    .iCLOCK(clk), .iRESET(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_player(in_player), .in_opponent(in_opponent), .in_tag(in_tag),
    .oPlayer(oPlayer), .oOpponent(oOpponent),
    .iTake(iTake), .iTakeSlot(iTakeSlot),
    .iSolved(iSolved), .iSolvedSlot(iSolvedSlot), .iRes(iRes),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_res(out_res),
    .oInflight(oInflight)
  );

  int ntot = 0;
  int npass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: task queue, per-slot ownership table, result queue.
  typedef struct {
    logic [63:0] p;
    logic [63:0] o;
    logic [7:0]  tag;
  } mtask_t;

  mtask_t      in_q[$];
  logic [15:0] res_q[$];
  bit          mvalid[16];
  logic [7:0]  mtag[16];
  bit          armed = 1'b0;

  always @(negedge clk) begin : model
    int infl;
    bit g;
    bit cp;
    infl = 0;
    foreach (mvalid[i]) infl += int'(mvalid[i]);
    g  = (in_q.size() > 0) && ((infl + res_q.size()) < D);
    cp = in_q.size() < D;
    if (armed) begin
      chk("m_in_ready", in_ready, cp);
      chk("m_out_valid", out_valid, res_q.size() > 0);
      chk("m_out_data", {out_tag, out_res}, (res_q.size() > 0) ? res_q[0] : 16'h0);
      chk("m_inflight", oInflight, infl[4:0]);
      chk("m_player", oPlayer, g ? in_q[0].p : ONES);
      chk("m_opponent", oOpponent, g ? in_q[0].o : 64'h0);
    end
    if (rst) begin
      in_q.delete();
      res_q.delete();
      foreach (mvalid[i]) mvalid[i] = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      if (out_ready && res_q.size() > 0) void'(res_q.pop_front());
      if (iSolved && mvalid[iSolvedSlot]) begin
        res_q.push_back({mtag[iSolvedSlot], iRes});
        mvalid[iSolvedSlot] = 1'b0;
      end
      if (iTake) begin
        if (g) begin
          mtag[iTakeSlot]   = in_q[0].tag;
          mvalid[iTakeSlot] = 1'b1;
          void'(in_q.pop_front());
        end else begin
          mvalid[iTakeSlot] = 1'b0;
        end
      end
      if (in_valid && cp) in_q.push_back('{in_player, in_opponent, in_tag});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    iTake    = 1'b0;
    iSolved  = 1'b0;
  endtask

  task automatic push(input logic [7:0] tag, input logic [63:0] p, input logic [63:0] o);
    in_valid = 1'b1; in_tag = tag; in_player = p; in_opponent = o;
  endtask

  initial begin
    int n;
    rst = 1'b1; out_ready = 1'b0; idle();
    in_player = '0; in_opponent = '0; in_tag = '0;
    iTakeSlot = '0; iSolvedSlot = '0; iRes = '0;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_inflight", oInflight, 5'd0);
    chk("rst_out_tag", out_tag, 8'h00);
    chk("rst_player", oPlayer, ONES);
    chk("rst_opponent", oOpponent, 64'h0);

    // Single task through slot 3
    push(8'h05, OPEN_P, OPEN_O); step(); idle();
    chk("s1_head_player", oPlayer, OPEN_P);
    chk("s1_head_opp", oOpponent, OPEN_O);
    iTake = 1'b1; iTakeSlot = 4'd3; step(); idle();
    chk("s1_inflight1", oInflight, 5'd1);
    chk("s1_dummy", oPlayer, ONES);
    repeat (19) step();
    iSolved = 1'b1; iSolvedSlot = 4'd3; iRes = 8'd0; step(); idle();
    chk("s1_out_valid", out_valid, 1'b1);
    chk("s1_out_tag", out_tag, 8'h05);
    chk("s1_out_res", out_res, 8'h00);
    chk("s1_inflight0", oInflight, 5'd0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("s1_drained", out_valid, 1'b0);

    // Dummy take and solve on slot 2
    iTake = 1'b1; iTakeSlot = 4'd2; step(); idle();
    chk("s2_inflight", oInflight, 5'd0);
    iSolved = 1'b1; iSolvedSlot = 4'd2; iRes = 8'hC0; step(); idle();
    chk("s2_no_output", out_valid, 1'b0);

    // Same-edge solve and take on slot 4
    push(8'h0A, 64'h1111, 64'h2222); step(); idle();
    iTake = 1'b1; iTakeSlot = 4'd4; step(); idle();
    push(8'h0B, 64'h3333, 64'h4444); step(); idle();
    iSolved = 1'b1; iSolvedSlot = 4'd4; iRes = 8'd12;
    iTake = 1'b1; iTakeSlot = 4'd4; step(); idle();
    chk("s3_tag_old", out_tag, 8'h0A);
    chk("s3_res", out_res, 8'h0C);
    chk("s3_inflight", oInflight, 5'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    iSolved = 1'b1; iSolvedSlot = 4'd4; iRes = 8'hF6; step(); idle();
    chk("s3_tag_new", out_tag, 8'h0B);
    chk("s3_res_neg", out_res, 8'hF6);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Credit exhaustion: 20 tasks, result FIFO blocked
    for (int k = 0; k < 22; k++) begin
      in_valid = (k < 20);
      in_tag = 8'(8'h20 + k);
      in_player = {32'(k), 32'hC0FF_EE00};
      in_opponent = {32'h0, 32'(k)};
      iTake = (k >= 1) && (k <= 20);
      iTakeSlot = 4'(k - 1);
      iSolved = (k >= 2);
      iSolvedSlot = 4'(k - 2);
      iRes = 8'(k);
      step();
    end
    idle();
    chk("s4_full_valid", out_valid, 1'b1);
    chk("s4_inflight", oInflight, 5'd0);
    chk("s4_no_credit", oPlayer, ONES);
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && out_valid; i++) begin step(); n++; end
    chk("s4_stored", 32'(n), 32'd16);
    chk("s4_next_head", oPlayer, {32'd16, 32'hC0FF_EE00});
    for (int i = 0; i < 5; i++) begin
      iTake = (i < 4); iTakeSlot = 4'(i);
      iSolved = (i > 0); iSolvedSlot = 4'(i - 1); iRes = 8'(i);
      step();
    end
    idle(); step(); out_ready = 1'b0;
    chk("s4_empty", out_valid, 1'b0);

    // Fill input FIFO
    for (int k = 0; k < 16; k++) begin
      push(8'(8'h40 + k), {32'(k), 32'h5A5A_0000}, 64'(k)); step();
    end
    push(8'h50, 64'hDEAD, 64'hBEEF);
    chk("s5_full", in_ready, 1'b0);
    iTake = 1'b1; iTakeSlot = 4'd0; step(); idle();
    chk("s5_ready_again", in_ready, 1'b1);
    chk("s5_order", oPlayer, {32'd1, 32'h5A5A_0000});
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      iTake = (i < 15); iTakeSlot = 4'(i + 1);
      iSolved = 1'b1; iSolvedSlot = 4'(i); iRes = 8'(8'h80 + i);
      step();
    end
    idle(); step(); out_ready = 1'b0;

    // Reset with work in flight
    for (int k = 0; k < 3; k++) begin push(8'(8'h60 + k), 64'(k), 64'(~k)); step(); end
    idle();
    for (int k = 0; k < 3; k++) begin iTake = 1'b1; iTakeSlot = 4'(k + 1); step(); end
    idle();
    push(8'h63, 64'h63, 64'h0); step();
    push(8'h64, 64'h64, 64'h0); step(); idle();
    iTake = 1'b1; iTakeSlot = 4'd5; step();
    iTakeSlot = 4'd6; iSolved = 1'b1; iSolvedSlot = 4'd5; iRes = 8'd1; step(); idle();
    iSolved = 1'b1; iSolvedSlot = 4'd6; iRes = 8'd2; step(); idle();
    chk("s6_inflight3", oInflight, 5'd3);
    chk("s6_queued", out_valid, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("s6_rst_valid", out_valid, 1'b0);
    chk("s6_rst_inflight", oInflight, 5'd0);
    chk("s6_rst_ready", in_ready, 1'b1);
    iSolved = 1'b1; iSolvedSlot = 4'd1; iRes = 8'd7; step(); idle();
    chk("s6_discard", out_valid, 1'b0);
    repeat (2) step();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
